gate_request_issuer: RTL and testbench
======================================

# gate_request_issuer

Front-end sequencer for the event gate. It buffers ticket-scan events (entry or exit, person type, event ID) in a small FIFO and issues them one at a time to the seat allocator over a valid/ready request channel. It waits for the allocator's grant/deny response and drives the turnstile-open and deny indicators. It sits between the scanner inputs and the Switcher/Count_Adder/TC/PC counting path, as the initiating end of the allocation protocol.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- OPEN_CYCLES, 8: cycles Gate_Open stays high after a grant; 1..255.
- TIMEOUT, 15: maximum cycles spent in WAIT before forced abort; 1..255. Used only with GATE_TIMEOUT_EN.
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  reset, asynchronous, active-high.
- Scan_Valid  in  1  one-cycle pulse per scanned ticket.
- Scan_Exit  in  1  0 = entry, 1 = exit.
- Scan_P  in  2  person type (00 = general).
- Scan_E  in  2  event ID.
- Scan_Drop  out  1  one-cycle pulse when a scan is rejected because the FIFO is full.
- Req_Valid  out  1  request valid toward the allocator.
- Req_Ready  in  1  allocator accepts the request.
- Req_Exit  out  1  direction of the head request.
- Req_P  out  2  person type of the head request.
- Req_E  out  2  event ID of the head request.
- Rsp_Valid  in  1  allocator response strobe.
- Rsp_Grant  in  1  1 = grant, 0 = deny; qualified by Rsp_Valid.
- Gate_Open  out  1  turnstile release.
- Deny_LED  out  1  one-cycle pulse on deny or abort.
- Timeout_Err  out  1  one-cycle pulse on response timeout; tied to 0 without GATE_TIMEOUT_EN.
- Fifo_Count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- Busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FIFO: circular buffer, 5-bit entries {Exit, P[1:0], E[1:0]}. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Push occurs on Scan_Valid when Fifo_Count < DEPTH, or when Fifo_Count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the scan is discarded and Scan_Drop pulses.
  - A simultaneous push and pop leaves Fifo_Count unchanged.
- FSM states: IDLE, ISSUE, WAIT, OPEN.
  - IDLE: if Fifo_Count != 0, go to ISSUE.
  - ISSUE: Req_Valid = 1 and Req_* = FIFO head. Req_Valid and Req_* stay stable until Req_Ready is sampled high; Req_Valid is never retracted. On Req_Valid & Req_Ready: pop, go to WAIT.
  - WAIT: on Rsp_Valid & Rsp_Grant, go to OPEN and load the open counter with OPEN_CYCLES. On Rsp_Valid & ~Rsp_Grant, pulse Deny_LED and go to IDLE.
  - OPEN: Gate_Open = 1; the counter decrements each cycle. When it reaches 1, go to IDLE.
- Rsp_Valid outside WAIT is ignored.
- Req_Ready outside ISSUE is ignored.
- Scans are accepted in every state, including while Gate_Open is high.
- Req_* outputs are 0 whenever Req_Valid = 0.

## Timing
- Reset values: Req_Valid 0, Req_Exit/Req_P/Req_E 0, Gate_Open 0, Deny_LED 0, Scan_Drop 0, Timeout_Err 0, Fifo_Count 0, Busy 0. FSM state is IDLE and both pointers are 0.
- Clear asserted mid-operation: all outputs drop immediately (asynchronously), FIFO contents are discarded, and the request in flight is abandoned.
- Latency with an empty FIFO in IDLE: scan sampled at edge k → Fifo_Count = 1 after edge k → Req_Valid high after edge k+1.
- Handshake: the pop happens at the edge where Req_Valid & Req_Ready are both high. WAIT begins after that edge. A response is accepted no earlier than the following edge.
- Grant sampled at edge m: Gate_Open is high from edge m to edge m+OPEN_CYCLES, i.e. exactly OPEN_CYCLES cycles. Next Req_Valid earliest after edge m+OPEN_CYCLES+1.
- Deny sampled at edge m: Deny_LED is high for the one cycle after edge m. Next Req_Valid earliest after edge m+1.
- Scan_Drop is registered: it is high in the cycle after the rejected Scan_Valid.

## Configuration
- GATE_TIMEOUT_EN defined:
  - A wait counter is cleared on entry to WAIT and increments each cycle in WAIT.
  - If it reaches TIMEOUT without Rsp_Valid, the FSM returns to IDLE and Timeout_Err and Deny_LED pulse together for one cycle. The request is dropped, not retried.
  - Rsp_Valid on the same edge the count reaches TIMEOUT takes priority over the timeout.
- GATE_TIMEOUT_EN undefined: WAIT holds indefinitely until Rsp_Valid, the wait counter is not built, and Timeout_Err is constant 0.

## Test plan
- Reset, then one entry scan (P=00, E=10); Req_Ready=1 immediately; grant two cycles later → Req_Valid after edge k+1 with Req_E=10, Req_Exit=0; Gate_Open high exactly 8 cycles; Busy falls afterwards.
- Five scans on consecutive cycles, DEPTH=4, Req_Ready=0 → Fifo_Count saturates at 4 and the fifth scan pulses Scan_Drop. Then grant each request: the four accepted scans are issued in FIFO order.
- Hold Req_Ready low for 10 cycles in ISSUE, with a scan arriving meanwhile → Req_Valid and Req_* stay constant throughout; the pop occurs only on the Ready edge.
- Deny response (Rsp_Grant=0) → Deny_LED pulses for 1 cycle, Gate_Open stays 0, and the next queued request is issued 1 cycle later.
- GATE_TIMEOUT_EN, TIMEOUT=15, no response → Timeout_Err and Deny_LED pulse after 15 WAIT cycles and the FSM returns to IDLE. Without the macro, Busy stays 1 for more than 100 cycles.
- Clear pulsed during OPEN with Fifo_Count=3 → Gate_Open and all other outputs drop immediately, and Fifo_Count reads 0.

Source files
------------

// File: rtl/gate_request_issuer.sv
// gate_request_issuer: scan FIFO plus request/response sequencer for the gate.
// Optional response timeout is enabled by defining GATE_TIMEOUT_EN.
module gate_request_issuer #(
    parameter int DEPTH       = 4,
    parameter int OPEN_CYCLES = 8,
    parameter int TIMEOUT     = 15
) (
    input  logic                   Clock,
    input  logic                   Clear,
    input  logic                   Scan_Valid,
    input  logic                   Scan_Exit,
    input  logic [1:0]             Scan_P,
    input  logic [1:0]             Scan_E,
    output logic                   Scan_Drop,
    output logic                   Req_Valid,
    input  logic                   Req_Ready,
    output logic                   Req_Exit,
    output logic [1:0]             Req_P,
    output logic [1:0]             Req_E,
    input  logic                   Rsp_Valid,
    input  logic                   Rsp_Grant,
    output logic                   Gate_Open,
    output logic                   Deny_LED,
    output logic                   Timeout_Err,
    output logic [$clog2(DEPTH):0] Fifo_Count,
    output logic                   Busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [7:0] OPEN_LOAD = 8'(OPEN_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OPEN
    } state_t;

    state_t state, state_nx;

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    open_cnt;
    logic          push, pop;
    logic          rsp_grant, rsp_deny, tmo;
    logic          drop_q, deny_q, tmo_q;

    assign pop       = (state == ISSUE) & Req_Ready;
    assign push      = Scan_Valid & ((count != FULL) | pop);
    assign rsp_grant = (state == WAIT) & Rsp_Valid & Rsp_Grant;
    assign rsp_deny  = (state == WAIT) & Rsp_Valid & ~Rsp_Grant;

`ifdef GATE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    // Wait counter: held at zero outside WAIT so it restarts on each entry.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // A response on the expiry edge wins over the timeout.
    assign tmo = (state == WAIT) & ~Rsp_Valid & (wait_cnt == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= {Scan_Exit, Scan_P, Scan_E};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Gate-open down-counter, loaded on grant.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            open_cnt <= '0;
        end else if (rsp_grant) begin
            open_cnt <= OPEN_LOAD;
        end else if ((state == OPEN) && (open_cnt != 8'd1)) begin
            open_cnt <= open_cnt - 8'd1;
        end
    end

    // Registered one-cycle indicator pulses.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            drop_q <= 1'b0;
            deny_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            drop_q <= Scan_Valid & ~push;
            deny_q <= rsp_deny | tmo;
            tmo_q  <= tmo;
        end
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state and state-decoded outputs.
    always_comb begin
        state_nx  = state;
        Req_Valid = 1'b0;
        Gate_Open = 1'b0;
        Busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                Req_Valid = 1'b1;
                if (Req_Ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (rsp_grant) begin
                    state_nx = OPEN;
                end else if (rsp_deny | tmo) begin
                    state_nx = IDLE;
                end
            end
            OPEN: begin
                Gate_Open = 1'b1;
                if (open_cnt == 8'd1) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign {Req_Exit, Req_P, Req_E} = Req_Valid ? mem[rd_ptr] : 5'd0;
    assign Scan_Drop   = drop_q;
    assign Deny_LED    = deny_q;
    assign Timeout_Err = tmo_q;
    assign Fifo_Count  = count;

endmodule

// File: tb/tb_gate_request_issuer.sv
// tb_gate_request_issuer: directed scenario bench for gate_request_issuer.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_gate_request_issuer;

    logic       Clock = 1'b0;
    logic       Clear;
    logic       Scan_Valid, Scan_Exit;
    logic [1:0] Scan_P, Scan_E;
    logic       Scan_Drop;
    logic       Req_Valid, Req_Ready, Req_Exit;
    logic [1:0] Req_P, Req_E;
    logic       Rsp_Valid, Rsp_Grant;
    logic       Gate_Open, Deny_LED, Timeout_Err;
    logic [2:0] Fifo_Count;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    logic [4:0]  req_f;
    logic [13:0] outs;

    assign req_f = {Req_Exit, Req_P, Req_E};
    assign outs  = {Req_Valid, Req_Exit, Req_P, Req_E, Gate_Open, Deny_LED,
                    Scan_Drop, Timeout_Err, Fifo_Count, Busy};

    gate_request_issuer #(
        .DEPTH(4),
        .OPEN_CYCLES(8),
        .TIMEOUT(15)
    ) dut (
        .Clock(Clock),
        .Clear(Clear),
        .Scan_Valid(Scan_Valid),
        .Scan_Exit(Scan_Exit),
        .Scan_P(Scan_P),
        .Scan_E(Scan_E),
        .Scan_Drop(Scan_Drop),
        .Req_Valid(Req_Valid),
        .Req_Ready(Req_Ready),
        .Req_Exit(Req_Exit),
        .Req_P(Req_P),
        .Req_E(Req_E),
        .Rsp_Valid(Rsp_Valid),
        .Rsp_Grant(Rsp_Grant),
        .Gate_Open(Gate_Open),
        .Deny_LED(Deny_LED),
        .Timeout_Err(Timeout_Err),
        .Fifo_Count(Fifo_Count),
        .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic scan(input logic [4:0] d);
        Scan_Valid = 1'b1;
        {Scan_Exit, Scan_P, Scan_E} = d;
    endtask

    task automatic unscan;
        Scan_Valid = 1'b0;
        {Scan_Exit, Scan_P, Scan_E} = 5'd0;
    endtask

    task automatic test_reset;
        Clear = 1'b1;
        unscan();
        Req_Ready = 1'b0;
        Rsp_Valid = 1'b0;
        Rsp_Grant = 1'b0;
        tick();
        tick();
        total++;
        if (outs !== 14'd0) begin
            bad++;
            $display("FAIL reset_outs got=%h want=0", outs);
        end
        Clear = 1'b0;
        tick();
        total++;
        if ({Busy, Fifo_Count, Req_Valid} !== 5'd0) begin
            bad++;
            $display("FAIL reset_idle got=%b want=00000", {Busy, Fifo_Count, Req_Valid});
        end
    endtask

    task automatic test_single;
        int n;
        Req_Ready = 1'b1;
        scan(5'b00010);
        tick();
        unscan();
        total++;
        if ({Fifo_Count, Req_Valid} !== {3'd1, 1'b0}) begin
            bad++;
            $display("FAIL lat_k got=%b want=0010", {Fifo_Count, Req_Valid});
        end
        tick();
        total++;
        if ({Req_Valid, req_f} !== 6'b1_00010) begin
            bad++;
            $display("FAIL lat_k1 got=%b want=100010", {Req_Valid, req_f});
        end
        tick();
        total++;
        if ({Req_Valid, Busy, Fifo_Count} !== {1'b0, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL single_pop got=%b want=01000", {Req_Valid, Busy, Fifo_Count});
        end
        Req_Ready = 1'b0;
        tick();
        total++;
        if (Gate_Open !== 1'b0) begin
            bad++;
            $display("FAIL wait_closed got=%b want=0", Gate_Open);
        end
        Rsp_Valid = 1'b1;
        Rsp_Grant = 1'b1;
        tick();
        Rsp_Valid = 1'b0;
        Rsp_Grant = 1'b0;
        n = 0;
        while (Gate_Open && n < 20) begin
            n++;
            tick();
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL open_len got=%0d want=8", n);
        end
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_open got=%b want=0", Busy);
        end
    endtask

    task automatic test_fill;
        logic [4:0] d [5];
        logic [2:0] exp_cnt [5];
        int n;
        d = '{5'b10110, 5'b00001, 5'b11011, 5'b01100, 5'b10011};
        exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        Req_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scan(d[i]);
            tick();
            total++;
            if ({Fifo_Count, Scan_Drop} !== {exp_cnt[i], (i == 4)}) begin
                bad++;
                $display("FAIL fill_%0d got=%b want=%b", i,
                         {Fifo_Count, Scan_Drop}, {exp_cnt[i], (i == 4)});
            end
        end
        unscan();
        tick();
        total++;
        if (Scan_Drop !== 1'b0) begin
            bad++;
            $display("FAIL drop_clear got=%b want=0", Scan_Drop);
        end
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!Req_Valid && n < 30) begin
                n++;
                tick();
            end
            total++;
            if ({Req_Valid, req_f} !== {1'b1, d[j]}) begin
                bad++;
                $display("FAIL order_%0d got=%b want=%b", j, {Req_Valid, req_f}, {1'b1, d[j]});
            end
            Req_Ready = 1'b1;
            tick();
            Req_Ready = 1'b0;
            total++;
            if (Fifo_Count !== 3'(3 - j)) begin
                bad++;
                $display("FAIL drain_cnt_%0d got=%0d want=%0d", j, Fifo_Count, 3 - j);
            end
            Rsp_Valid = 1'b1;
            Rsp_Grant = 1'b1;
            tick();
            Rsp_Valid = 1'b0;
            Rsp_Grant = 1'b0;
            total++;
            if (Gate_Open !== 1'b1) begin
                bad++;
                $display("FAIL drain_open_%0d got=%b want=1", j, Gate_Open);
            end
        end
        n = 0;
        while (Busy && n < 30) begin
            n++;
            tick();
        end
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL fill_idle got=%b want=0", Busy);
        end
    endtask

    task automatic test_stall;
        int errs;
        Req_Ready = 1'b0;
        scan(5'b01001);
        tick();
        unscan();
        tick();
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                scan(5'b10110);
            end else begin
                unscan();
            end
            tick();
            if ({Req_Valid, req_f} != 6'b1_01001) begin
                errs++;
            end
        end
        unscan();
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL stall_stable got=%0d want=0 unstable cycles", errs);
        end
        total++;
        if (Fifo_Count !== 3'd2) begin
            bad++;
            $display("FAIL stall_cnt got=%0d want=2", Fifo_Count);
        end
        Req_Ready = 1'b1;
        tick();
        Req_Ready = 1'b0;
        total++;
        if ({Req_Valid, Fifo_Count} !== {1'b0, 3'd1}) begin
            bad++;
            $display("FAIL stall_pop got=%b want=0001", {Req_Valid, Fifo_Count});
        end
    endtask

    task automatic test_deny;
        tick();
        Rsp_Valid = 1'b1;
        Rsp_Grant = 1'b0;
        tick();
        Rsp_Valid = 1'b0;
        total++;
        if ({Deny_LED, Gate_Open, Req_Valid} !== 3'b100) begin
            bad++;
            $display("FAIL deny_pulse got=%b want=100", {Deny_LED, Gate_Open, Req_Valid});
        end
        tick();
        total++;
        if ({Deny_LED, Req_Valid, req_f} !== 7'b0_1_10110) begin
            bad++;
            $display("FAIL deny_next got=%b want=0110110", {Deny_LED, Req_Valid, req_f});
        end
        Req_Ready = 1'b1;
        tick();
        Req_Ready = 1'b0;
        Rsp_Valid = 1'b1;
        tick();
        Rsp_Valid = 1'b0;
        tick();
        total++;
        if ({Busy, Gate_Open, Deny_LED, Fifo_Count} !== 6'd0) begin
            bad++;
            $display("FAIL deny_idle got=%b want=000000", {Busy, Gate_Open, Deny_LED, Fifo_Count});
        end
    endtask

    task automatic test_timeout;
        int errs;
        Req_Ready = 1'b1;
        scan(5'b11111);
        tick();
        unscan();
        tick();
        tick();
        Req_Ready = 1'b0;
        errs = 0;
`ifdef GATE_TIMEOUT_EN
        for (int c = 1; c < 15; c++) begin
            tick();
            if (Timeout_Err || Deny_LED || !Busy) begin
                errs++;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL tmo_early got=%0d want=0 bad cycles", errs);
        end
        tick();
        total++;
        if ({Timeout_Err, Deny_LED, Busy} !== 3'b110) begin
            bad++;
            $display("FAIL tmo_fire got=%b want=110", {Timeout_Err, Deny_LED, Busy});
        end
        tick();
        total++;
        if ({Timeout_Err, Deny_LED} !== 2'b00) begin
            bad++;
            $display("FAIL tmo_pulse got=%b want=00", {Timeout_Err, Deny_LED});
        end
`else
        for (int c = 0; c < 110; c++) begin
            tick();
            if (!Busy || Timeout_Err || Deny_LED) begin
                errs++;
            end
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL wait_hold got=%0d want=0 bad cycles", errs);
        end
        Rsp_Valid = 1'b1;
        Rsp_Grant = 1'b0;
        tick();
        Rsp_Valid = 1'b0;
        total++;
        if ({Deny_LED, Busy, Timeout_Err} !== 3'b100) begin
            bad++;
            $display("FAIL late_deny got=%b want=100", {Deny_LED, Busy, Timeout_Err});
        end
`endif
    endtask

    task automatic test_clear;
        tick();
        Req_Ready = 1'b1;
        scan(5'b00101);
        tick();
        scan(5'b01010);
        tick();
        scan(5'b10001);
        tick();
        Req_Ready = 1'b0;
        scan(5'b11100);
        Rsp_Valid = 1'b1;
        Rsp_Grant = 1'b1;
        tick();
        unscan();
        Rsp_Valid = 1'b0;
        Rsp_Grant = 1'b0;
        total++;
        if ({Gate_Open, Fifo_Count} !== {1'b1, 3'd3}) begin
            bad++;
            $display("FAIL pre_clear got=%b want=1011", {Gate_Open, Fifo_Count});
        end
        #2;
        Clear = 1'b1;
        #1;
        total++;
        if (outs !== 14'd0) begin
            bad++;
            $display("FAIL clear_async got=%h want=0", outs);
        end
        #2;
        Clear = 1'b0;
        tick();
        total++;
        if ({Fifo_Count, Busy, Req_Valid, Gate_Open} !== 6'd0) begin
            bad++;
            $display("FAIL post_clear got=%b want=000000",
                     {Fifo_Count, Busy, Req_Valid, Gate_Open});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_deny();
        test_timeout();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
